// File: rtl/noc_inj_pkg.sv
// Shared definitions for the NoC flit injector: flit type encoding, header
// field positions and the flit builder functions used by the injector.
package noc_inj_pkg;

    localparam int NOC_WIDTH     = 32;
    localparam int NOC_COORD_W   = 3;
    localparam int NOC_LEN_W     = 8;
    localparam int NOC_PAYLOAD_W = NOC_WIDTH - 2;

    // Flit type sits in the two MSBs. Below it, 2*COORD_W bits are left
    // reserved (zero), then X, then Y. The length/count field is at the bottom.
    localparam int TYPE_LSB = NOC_WIDTH - 2;
    localparam int X_LSB    = TYPE_LSB - 3 * NOC_COORD_W;
    localparam int Y_LSB    = X_LSB - NOC_COORD_W;
    localparam int LEN_LSB  = 0;

    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_TAIL = 2'b01,
        FLIT_HEAD = 2'b10
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_TAIL = 2'd3
    } inj_state_e;

    // HEAD and TAIL share one layout: coordinates plus a length/count field.
    function automatic logic [NOC_WIDTH-1:0] make_route(
        input flit_type_e             t,
        input logic [NOC_COORD_W-1:0] x,
        input logic [NOC_COORD_W-1:0] y,
        input logic [NOC_LEN_W-1:0]   n
    );
        logic [NOC_WIDTH-1:0] f;
        f = '0;
        f[TYPE_LSB +: 2]          = t;
        f[X_LSB +: NOC_COORD_W]   = x;
        f[Y_LSB +: NOC_COORD_W]   = y;
        f[LEN_LSB +: NOC_LEN_W]   = n;
        return f;
    endfunction

    function automatic logic [NOC_WIDTH-1:0] make_head(
        input logic [NOC_COORD_W-1:0] dst_x,
        input logic [NOC_COORD_W-1:0] dst_y,
        input logic [NOC_LEN_W-1:0]   len
    );
        return make_route(FLIT_HEAD, dst_x, dst_y, len);
    endfunction

    function automatic logic [NOC_WIDTH-1:0] make_body(
        input logic [NOC_PAYLOAD_W-1:0] payload
    );
        return {FLIT_BODY, payload};
    endfunction

    // The tail carries the source coordinates and the number of bodies sent.
    function automatic logic [NOC_WIDTH-1:0] make_tail(
        input logic [NOC_COORD_W-1:0] src_x,
        input logic [NOC_COORD_W-1:0] src_y,
        input logic [NOC_LEN_W-1:0]   sent
    );
        return make_route(FLIT_TAIL, src_x, src_y, sent);
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit tracker. Counts free slots in the receiving buffer,
// allows a send whenever at least one credit is held, and flags (sticky)
// any credit return that arrives while the counter is already full.
module noc_credit_counter #(
    parameter int CREDITS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ret,
    input  logic i_sent,
    output logic o_send_en,
    output logic o_credit_err
);

    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] r_count;
    logic             r_err;

    // Credit count: return and send in the same cycle cancel out; an
    // overflowing return saturates and latches the error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= FULL;
            r_err   <= 1'b0;
        end else if (i_ret && !i_sent) begin
            if (r_count == FULL) begin
                r_err <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_sent && !i_ret) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_send_en    = (r_count != '0);
    assign o_credit_err = r_err;

endmodule

// File: rtl/noc_flit_injector.sv
// Packet source for a router local port. Accepts one request at a time and
// emits HEAD, len BODY flits and TAIL on a void/stop link, one flit per cycle
// whenever a downstream credit is held.
// Optional build macro INJ_STATS_EN adds pkt_count / stall_count outputs.
module noc_flit_injector
    import noc_inj_pkg::*;
#(
    parameter int WIDTH   = NOC_WIDTH,
    parameter int CREDITS = 5,
    parameter int COORD_W = NOC_COORD_W,
    parameter int LEN_W   = NOC_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] local_x,
    input  logic [COORD_W-1:0] local_y,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_dst_x,
    input  logic [COORD_W-1:0] req_dst_y,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [WIDTH-3:0]   req_seed,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_void_out,
    input  logic               stop_in,
    output logic               busy,
    output logic               credit_err
`ifdef INJ_STATS_EN
    ,
    output logic [31:0]        pkt_count,
    output logic [31:0]        stall_count
`endif
);

    inj_state_e         r_state;
    inj_state_e         w_state_next;
    logic [COORD_W-1:0] r_dst_x;
    logic [COORD_W-1:0] r_dst_y;
    logic [LEN_W-1:0]   r_len;
    logic [WIDTH-3:0]   r_seed;
    logic [LEN_W-1:0]   r_body_cnt;
    logic [WIDTH-1:0]   r_last;
    logic               r_run;

    logic               w_send_en;
    logic               w_sending;
    logic               w_ready;
    logic               w_accept;
    logic               w_credit_ret;
    logic [WIDTH-1:0]   w_flit;

    assign w_credit_ret = ~stop_in;

    noc_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .i_ret        (w_credit_ret),
        .i_sent       (w_sending),
        .o_send_en    (w_send_en),
        .o_credit_err (credit_err)
    );

    // r_run keeps req_ready low while reset is held and for the first cycle after release.
    assign w_ready   = r_run && (r_state == ST_IDLE);
    assign w_accept  = req_valid && w_ready;
    assign w_sending = (r_state != ST_IDLE) && w_send_en;

    assign req_ready     = w_ready;
    assign busy          = (r_state != ST_IDLE);
    assign data_void_out = ~w_sending;
    assign data_out      = w_sending ? w_flit : r_last;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and the flit for the current state; states only advance on a sending cycle.
    always_comb begin
        w_state_next = r_state;
        w_flit       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_HEAD;
                end
            end
            ST_HEAD: begin
                w_flit = make_head(r_dst_x, r_dst_y, r_len);
                if (w_send_en) begin
                    w_state_next = (r_len == '0) ? ST_TAIL : ST_BODY;
                end
            end
            ST_BODY: begin
                w_flit = make_body(r_seed + (WIDTH-2)'(r_body_cnt));
                if (w_send_en && (r_body_cnt == r_len - 1'b1)) begin
                    w_state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                w_flit = make_tail(local_x, local_y, r_body_cnt);
                if (w_send_en) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request capture, body counter and the held copy of the last driven flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dst_x    <= '0;
            r_dst_y    <= '0;
            r_len      <= '0;
            r_seed     <= '0;
            r_body_cnt <= '0;
            r_last     <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_dst_x    <= req_dst_x;
                r_dst_y    <= req_dst_y;
                r_len      <= req_len;
                r_seed     <= req_seed;
                r_body_cnt <= '0;
            end
            if (w_sending) begin
                r_last <= w_flit;
                if (r_state == ST_BODY) begin
                    r_body_cnt <= r_body_cnt + 1'b1;
                end
            end
        end
    end

`ifdef INJ_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_stall_count;

    // Packet and stall statistics; both counters wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_sending && (r_state == ST_TAIL)) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (busy && !w_send_en) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign pkt_count   = r_pkt_count;
    assign stall_count = r_stall_count;
`else
    // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Bench for noc_flit_injector: two instances (CREDITS=5 and CREDITS=2) share
// the same stimulus and are compared cycle by cycle against a packet-level
// reference model (flit list per packet plus an integer credit count).
module tb_noc_flit_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  local_x, local_y, req_dst_x, req_dst_y;
    logic        req_valid, stop_in;
    logic [7:0]  req_len;
    logic [29:0] req_seed;
    logic        req_ready [2];
    logic        data_void_out [2];
    logic        busy [2];
    logic        credit_err [2];
    logic [31:0] data_out [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noc_flit_injector #(.CREDITS(5)) u_dut_c5 (
        .clk(clk), .rst(rst), .local_x(local_x), .local_y(local_y),
        .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len), .req_seed(req_seed),
        .data_out(data_out[0]), .data_void_out(data_void_out[0]), .stop_in(stop_in),
        .busy(busy[0]), .credit_err(credit_err[0])
    );

    noc_flit_injector #(.CREDITS(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .local_x(local_x), .local_y(local_y),
        .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len), .req_seed(req_seed),
        .data_out(data_out[1]), .data_void_out(data_void_out[1]), .stop_in(stop_in),
        .busy(busy[1]), .credit_err(credit_err[1])
    );

    // ---------------- reference model ----------------
    logic [31:0] pk [2][0:299];
    int          pk_len [2];
    int          pk_pos [2];
    int          mcred [2];
    bit          merr [2];
    bit          mrun [2];
    logic [31:0] mlast [2];

    function automatic int cap(int m);
        return (m == 0) ? 5 : 2;
    endfunction
    function automatic bit m_busy(int m);
        return pk_pos[m] < pk_len[m];
    endfunction
    function automatic bit m_send(int m);
        return m_busy(m) && (mcred[m] != 0);
    endfunction
    function automatic logic [31:0] m_data(int m);
        return m_send(m) ? pk[m][pk_pos[m]] : mlast[m];
    endfunction
    function automatic bit m_ready(int m);
        return mrun[m] && !m_busy(m);
    endfunction
    function automatic logic [35:0] m_exp(int m);
        return {m_data(m), ~m_send(m), m_busy(m), m_ready(m), merr[m]};
    endfunction
    function automatic logic [35:0] dut_obs(int m);
        return {data_out[m], data_void_out[m], busy[m], req_ready[m], credit_err[m]};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pk_len[m] = 0; pk_pos[m] = 0; mcred[m] = cap(m);
            merr[m] = 1'b0; mrun[m] = 1'b0; mlast[m] = '0;
        end
    endtask

    // Advance the model over one clock edge using the inputs currently applied.
    task automatic model_step();
        bit s, rdy;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            s   = m_send(m);
            rdy = m_ready(m);
            if (s) begin
                mlast[m] = pk[m][pk_pos[m]];
                pk_pos[m]++;
            end
            if (!stop_in && !s) begin
                if (mcred[m] == cap(m)) merr[m] = 1'b1;
                else mcred[m]++;
            end else if (s && stop_in) begin
                mcred[m]--;
            end
            if (rdy && req_valid) begin
                pk[m][0] = {2'b10, 6'b0, req_dst_x, req_dst_y, 10'b0, req_len};
                for (int k = 0; k < int'(req_len); k++)
                    pk[m][1 + k] = {2'b00, req_seed + 30'(k)};
                pk[m][1 + int'(req_len)] = {2'b01, 6'b0, local_x, local_y, 10'b0, req_len};
                pk_len[m] = int'(req_len) + 2;
                pk_pos[m] = 0;
            end
            mrun[m] = 1'b1;
        end
    endtask

    task automatic run_cycle();
        model_step();
        @(negedge clk);
    endtask

    // One cycle; drop the request once the CREDITS=5 instance has taken it.
    task automatic advance();
        bit acc;
        acc = req_valid && req_ready[0];
        run_cycle();
        if (acc) req_valid = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] dx, input logic [2:0] dy,
                           input logic [7:0] len, input logic [29:0] seed);
        req_dst_x = dx; req_dst_y = dy; req_len = len; req_seed = seed; req_valid = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; stop_in = 1'b1;
        model_reset();
        run_cycle();
        run_cycle();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (dut_obs(m) !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values dut%0d got=%h exp=%h", m, dut_obs(m), {32'h0, 4'b1000});
            end
        end
        rst = 1'b1;
        run_cycle();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int flits, first, last;
        bit done;
        logic [31:0] tail_f;
        flits = 0; first = -1; last = -1; done = 1'b0; tail_f = '0;
        stop_in = 1'b0;
        set_req(3'd3, 3'd2, 8'd5, 30'd1);
        for (int c = 0; c < 40; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL single_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            if (!data_void_out[0]) begin
                flits++;
                if (first < 0) first = c;
                last = c; tail_f = data_out[0];
            end
            if (!req_valid && !busy[0] && !busy[1]) begin done = 1'b1; break; end
            advance();
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL single_timeout got=busy exp=idle"); end
        n_checks++;
        if (flits != 7) begin n_fail++; $display("FAIL single_flits got=%0d exp=7", flits); end
        n_checks++;
        if (last - first != 6) begin n_fail++; $display("FAIL single_span got=%0d exp=6", last - first); end
        n_checks++;
        if (tail_f !== {2'b01, 6'b0, local_x, local_y, 10'b0, 8'd5}) begin
            n_fail++; $display("FAIL single_tail got=%h", tail_f);
        end
        $display("test_single flits=%0d", flits);
    endtask

    task automatic test_stop();
        int n0, n1;
        bit done;
        n0 = 0; n1 = 0; done = 1'b0;
        stop_in = 1'b1;
        set_req(3'd1, 3'd6, 8'd6, 30'($urandom));
        for (int c = 0; c < 15; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL stop_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            n0 += int'(!data_void_out[0]); n1 += int'(!data_void_out[1]);
            advance();
        end
        n_checks++;
        if (n1 != 2) begin n_fail++; $display("FAIL stop_held_c2 got=%0d exp=2", n1); end
        n_checks++;
        if (n0 != 5) begin n_fail++; $display("FAIL stop_held_c5 got=%0d exp=5", n0); end
        n0 = 0; n1 = 0;
        for (int c = 0; c < 8; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL pulse_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            n0 += int'(!data_void_out[0]); n1 += int'(!data_void_out[1]);
            stop_in = (c == 0) ? 1'b0 : 1'b1;
            advance();
        end
        n_checks++;
        if (n1 != 1) begin n_fail++; $display("FAIL stop_pulse_c2 got=%0d exp=1", n1); end
        n_checks++;
        if (n0 != 1) begin n_fail++; $display("FAIL stop_pulse_c5 got=%0d exp=1", n0); end
        stop_in = 1'b0;
        for (int c = 0; c < 40; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL stop_drain dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            if (!busy[0] && !busy[1]) begin done = 1'b1; break; end
            advance();
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL stop_timeout got=busy exp=idle"); end
        $display("test_stop done");
    endtask

    task automatic test_zero_len();
        int nb, nf;
        bit done;
        logic [31:0] last_f;
        nb = 0; nf = 0; done = 1'b0; last_f = '0;
        stop_in = 1'b0;
        set_req(3'($urandom), 3'($urandom), 8'd0, 30'($urandom));
        for (int c = 0; c < 20; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL zero_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            nb += int'(busy[0]);
            if (!data_void_out[0]) begin nf++; last_f = data_out[0]; end
            if (!req_valid && !busy[0] && !busy[1]) begin done = 1'b1; break; end
            advance();
        end
        n_checks++;
        if (!done || nb != 2) begin n_fail++; $display("FAIL zero_busy got=%0d exp=2", nb); end
        n_checks++;
        if (nf != 2) begin n_fail++; $display("FAIL zero_flits got=%0d exp=2", nf); end
        n_checks++;
        if (last_f !== {2'b01, 6'b0, local_x, local_y, 18'b0}) begin
            n_fail++; $display("FAIL zero_tail got=%h", last_f);
        end
        $display("test_zero_len busy=%0d", nb);
    endtask

    task automatic test_back_to_back();
        int acc_n, t1, h2;
        bit done, acc;
        logic [31:0] head2;
        acc_n = 0; t1 = -1; h2 = -1; done = 1'b0; head2 = '0;
        stop_in = 1'b0;
        set_req(3'd2, 3'd7, 8'd3, 30'($urandom));
        for (int c = 0; c < 60; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL b2b_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            if (!data_void_out[0]) begin
                if (data_out[0][31:30] == 2'b01 && t1 < 0) t1 = c;
                if (data_out[0][31:30] == 2'b10 && t1 >= 0 && h2 < 0) begin
                    h2 = c; head2 = data_out[0];
                end
            end
            if (acc_n == 2 && !busy[0] && !busy[1]) begin done = 1'b1; break; end
            acc = req_valid && req_ready[0];
            run_cycle();
            if (acc) begin
                acc_n++;
                if (acc_n == 1) set_req(3'd5, 3'd1, 8'd2, 30'($urandom));
                else req_valid = 1'b0;
            end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL b2b_timeout got=%0d accepts exp=2", acc_n); end
        n_checks++;
        if (h2 - t1 != 2) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=2", h2 - t1); end
        n_checks++;
        if (head2 !== {2'b10, 6'b0, 3'd5, 3'd1, 10'b0, 8'd2}) begin
            n_fail++; $display("FAIL b2b_head2 got=%h", head2);
        end
        $display("test_back_to_back gap=%0d", h2 - t1);
    endtask

    task automatic test_credit_err();
        int n0, n1;
        bit done;
        n0 = 0; n1 = 0; done = 1'b0;
        rst = 1'b0; req_valid = 1'b0; stop_in = 1'b1;
        model_reset();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (credit_err[m] !== 1'b0) begin n_fail++; $display("FAIL err_clear dut%0d got=%b exp=0", m, credit_err[m]); end
        end
        stop_in = 1'b0;
        run_cycle();
        stop_in = 1'b1;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (credit_err[m] !== 1'b1) begin n_fail++; $display("FAIL err_set dut%0d got=%b exp=1", m, credit_err[m]); end
        end
        set_req(3'd0, 3'd0, 8'd8, 30'($urandom));
        for (int c = 0; c < 20; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL err_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            n0 += int'(!data_void_out[0]); n1 += int'(!data_void_out[1]);
            advance();
        end
        n_checks++;
        if (n0 != 5) begin n_fail++; $display("FAIL err_sat_c5 got=%0d exp=5", n0); end
        n_checks++;
        if (n1 != 2) begin n_fail++; $display("FAIL err_sat_c2 got=%0d exp=2", n1); end
        stop_in = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!busy[0] && !busy[1]) begin done = 1'b1; break; end
            advance();
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL err_timeout got=busy exp=idle"); end
        $display("test_credit_err n0=%0d n1=%0d", n0, n1);
    endtask

    task automatic test_reset_mid();
        int flits;
        bit done;
        logic [31:0] first_f;
        flits = 0; done = 1'b0; first_f = '0;
        stop_in = 1'b0;
        set_req(3'($urandom), 3'($urandom), 8'd10, 30'($urandom));
        for (int c = 0; c < 30; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL mid_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            flits += int'(!data_void_out[0]);
            if (flits == 4) break;
            advance();
        end
        n_checks++;
        if (flits != 4) begin n_fail++; $display("FAIL mid_reach got=%0d exp=4", flits); end
        rst = 1'b0; req_valid = 1'b0;
        model_reset();
        run_cycle();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (dut_obs(m) !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL mid_reset dut%0d got=%h exp=%h", m, dut_obs(m), {32'h0, 4'b1000});
            end
        end
        rst = 1'b1;
        run_cycle();
        set_req(3'd4, 3'd4, 8'd2, 30'($urandom));
        for (int c = 0; c < 30; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL restart_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            if (!data_void_out[0] && first_f == '0) first_f = data_out[0];
            if (!req_valid && !busy[0] && !busy[1]) begin done = 1'b1; break; end
            advance();
        end
        n_checks++;
        if (!done || first_f !== {2'b10, 6'b0, 3'd4, 3'd4, 10'b0, 8'd2}) begin
            n_fail++; $display("FAIL restart_head got=%h", first_f);
        end
        $display("test_reset_mid first=%h", first_f);
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL rand_cycle dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            stop_in = 1'($urandom_range(0, 1));
            if (!req_valid && c < 700 && $urandom_range(0, 2) == 0)
                set_req(3'($urandom), 3'($urandom), 8'($urandom_range(0, 12)), 30'($urandom));
            advance();
        end
        req_valid = 1'b0;
        stop_in = 1'b0;
        for (int c = 0; c < 100; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (dut_obs(m) !== m_exp(m)) begin
                    n_fail++;
                    $display("FAIL rand_drain dut%0d c=%0d got=%h exp=%h", m, c, dut_obs(m), m_exp(m));
                end
            end
            if (!busy[0] && !busy[1]) begin done = 1'b1; break; end
            advance();
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rand_timeout got=busy exp=idle"); end
        $display("test_random done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; stop_in = 1'b1;
        req_dst_x = '0; req_dst_y = '0; req_len = '0; req_seed = '0;
        local_x = 3'($urandom_range(0, 7));
        local_y = 3'($urandom_range(0, 7));
        model_reset();
        test_reset();
        test_single();
        test_stop();
        test_zero_len();
        test_back_to_back();
        test_credit_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
